// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-port bundle for fifo_wr_arbiter.
// master: arbiter side; slave: requesters plus FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int NumReq    = 4
);
  localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [NumReq-1:0]                req;
  logic [NumReq-1:0][DataWidth-1:0] reqData;
  logic [NumReq-1:0]                reqLast;
  logic [NumReq-1:0]                ack;
  logic                             full;
  logic                             writeEn;
  logic [DataWidth-1:0]             writeData;
  logic                             grantValid;
  logic [IdW-1:0]                   grantId;
  logic                             trunc;

  modport master (
    input  req, reqData, reqLast, full,
    output ack, writeEn, writeData,
    output grantValid, grantId, trunc
  );

  modport slave (
    output req, reqData, reqLast, full,
    input  ack, writeEn, writeData,
    input  grantValid, grantId, trunc
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester the FIFO write port per packet.
// Ports: clk, rst (sync, active-high), bus (req/data/last in, ack/write/grant out).
module fifo_wr_arbiter #(
  parameter int DataWidth = 32,
  parameter int NumReq    = 4,
  parameter int MaxBeats  = 8
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(MaxBeats + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IdW-1:0]  gid_q, gid_d;
  logic [IdW-1:0]  last_q, last_d;
  logic [IdW-1:0]  pick, cand;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            found;
  logic            busy;
  logic            accept;
  logic            at_max;
  logic            done;

  // Rotating search starting just after the previous owner.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = IdW'((int'(last_q) + k) % NumReq);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Outputs are forced low while rst is high so a
  // mid-packet reset cannot push one more beat.
  assign busy   = (state_q == BUSY) && !rst;
  assign accept = busy && bus.req[gid_q] && !bus.full;
  assign at_max = (cnt_q == CntW'(MaxBeats - 1));
  assign done   = accept
                && (bus.reqLast[gid_q] || at_max);

  assign bus.writeEn    = accept;
  assign bus.grantValid = busy;
  assign bus.grantId    = busy ? gid_q : '0;
  assign bus.writeData  = busy ? bus.reqData[gid_q]
                               : '0;
  assign bus.trunc      = accept && at_max
                        && !bus.reqLast[gid_q];

  always_comb begin
    bus.ack = '0;
    if (accept) begin
      bus.ack[gid_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gid_d   = pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
          last_d  = gid_q;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      last_q  <= IdW'(NumReq - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DataWidth, default 32, width of each requester data word and of writeData.
REQ-002 Parameter NumReq, default 4, number of requesters, range 2..8.
REQ-003 Parameter MaxBeats, default 8, maximum beats per grant before forced release, range 1..256.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  NumReq  per-requester request; bit i high means a beat is offered on reqData[i].
REQ-008 reqData  input  NumReq x DataWidth  per-requester data word.
REQ-009 reqLast  input  NumReq  per-requester end-of-packet marker for the offered beat.
REQ-010 ack  output  NumReq  one-hot per-requester beat-accepted strobe.
REQ-011 full  input  1  FIFO full flag.
REQ-012 writeEn  output  1  FIFO write enable.
REQ-013 writeData  output  DataWidth  FIFO write data.
REQ-014 grantValid  output  1  high while a requester owns the FIFO write port.
REQ-015 grantId  output  clog2(NumReq)  index of the current owner, valid when grantValid is high.
REQ-016 trunc  output  1  one-cycle pulse when a grant is force-released at MaxBeats.

Function
REQ-017 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-018 In IDLE with any req bit high, the block SHALL select the first requester with req high, searching upward from lastGrant+1 modulo NumReq, and SHALL enter BUSY next cycle with grantId set to the selected index.
REQ-019 Arbitration latency SHALL be exactly one cycle; writeEn SHALL be low in every IDLE cycle.
REQ-020 In BUSY, writeEn SHALL equal req[grantId] AND NOT full, combinationally.
REQ-021 ack[grantId] SHALL equal writeEn; all other ack bits SHALL be 0.
REQ-022 writeData SHALL equal reqData[grantId] combinationally in BUSY, and 0 in IDLE.
REQ-023 A beat is accepted when writeEn is high; the beat counter SHALL increment by 1 on each accepted beat and reset to 0 when leaving BUSY.
REQ-024 On an accepted beat with reqLast[grantId] high, the block SHALL return to IDLE next cycle and set lastGrant to grantId.
REQ-025 On an accepted beat that is beat number MaxBeats (counter equals MaxBeats-1) with reqLast low, the block SHALL return to IDLE, update lastGrant, and pulse trunc high for that same cycle.
REQ-026 If reqLast is high on the MaxBeats-th beat, the block SHALL release normally and trunc SHALL stay low.
REQ-027 While full is high, writeEn and ack SHALL stay low, and the grant and beat counter SHALL hold.
REQ-028 If req[grantId] drops in BUSY, the grant SHALL be held; other requesters SHALL NOT be served until release.
REQ-029 grantValid SHALL be high exactly in BUSY; grantId SHALL hold its value while in BUSY.
REQ-030 Changes on req bits of non-owners during BUSY SHALL have no effect until the next IDLE cycle.
REQ-031 Round-robin SHALL guarantee that any requester holding req high is granted within NumReq grants.

Reset
REQ-032 On rst high at a rising edge, the block SHALL enter IDLE, set lastGrant to NumReq-1, and clear the beat counter.
REQ-033 During reset and in the first cycle after it, writeEn, ack, grantValid, grantId, writeData and trunc SHALL be 0.
REQ-034 Reset asserted mid-packet SHALL abandon the grant without any further write.

Verification
REQ-035 After reset, req=4'b0101, each packet one beat with reqLast=1, full=0 -> grants in order 0,2,0,2; writeEn high every second cycle.
REQ-036 req=4'b1111, 3-beat packets -> grant order 0,1,2,3,0; exactly 3 writeEn pulses per grant; one IDLE cycle between grants.
REQ-037 Requester 1 sends 10 beats with no reqLast, MaxBeats=8 -> 8 writes, trunc pulses on the 8th accept, next grant goes to the next requester in round-robin order.
REQ-038 full raised for 3 cycles mid-packet -> no writeEn or ack for those 3 cycles, grantId unchanged, packet resumes with no lost beat and writeData unchanged.
REQ-039 rst asserted on the 2nd beat of a 4-beat packet -> next cycle IDLE, all outputs 0; after reset, requester 0 wins a tie against requester 3.
REQ-040 Formal: never two ack bits high; writeEn implies NOT full; writeEn implies grantValid.
